snake_step_engine: RTL and testbench
====================================

# snake_step_engine

Sequences the snake body datapath for the snake game. Each step tick, while the key controller reports PLAY, it:
- computes the next head position from the direction request;
- checks wall and self collision with a serial body scan;
- shifts the body and grows it on food.

It sits between the key controller (state, direction, speed) and the VGA renderer and food generator. It owns `game_over`, which feeds back to the key controller.

## Interface
Parameters:
- `GRID_W`, default 40: grid columns; x in 0..GRID_W-1.
- `GRID_H`, default 30: grid rows; y in 0..GRID_H-1.
- `MAX_LEN`, default 16: body segment capacity, minimum 4.
- `STEP_SLOW`, default 25_000_000: clk cycles of WAIT per step when `speed_m`=1.
- `STEP_FAST`, default 12_500_000: clk cycles of WAIT per step when `speed_m`=0.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low; clock clk.
- `state_m`  in  4  one-hot game state: START=0001, SPEED=0010, PLAY=0100, END=1000.
- `move_d`  in  4  one-hot direction request: RIGHT=0001, LEFT=0010, DOWN=0100, UP=1000.
- `speed_m`  in  1  1 = slow, 0 = fast.
- `food_x`  in  6  food column.
- `food_y`  in  5  food row.
- `rd_idx`  in  $clog2(MAX_LEN)  body read index; 0 = head.
- `rd_x`, `rd_y`  out  6/5  combinational read of segment `rd_idx`; returns 0 when `rd_idx` ≥ `snake_len`.
- `head_x`, `head_y`  out  6/5  current head.
- `snake_len`  out  $clog2(MAX_LEN+1)  live segment count.
- `food_eaten`  out  1  one-cycle pulse when the head lands on food.
- `step_done`  out  1  one-cycle pulse; the updated body is visible in that cycle.
- `game_over`  out  1  level; held until `state_m`=START.

## Operation
FSM states: IDLE, WAIT, CALC, SCAN, SHIFT, OVER.

- **Global rule (START):** `state_m`=START in any state forces IDLE next cycle and reinitialises the body.
  - Initial body: len=3; segments (GRID_W/2, GRID_H/2), (GRID_W/2-1, GRID_H/2), (GRID_W/2-2, GRID_H/2).
  - Applied direction becomes RIGHT; `game_over`=0; step counter cleared.
- **Global rule (pause):** SPEED or END in WAIT/CALC/SCAN/SHIFT freezes all state: no counter advance, no body change.
- **IDLE:** on `state_m`=PLAY go to WAIT with counter=0.
- **WAIT:**
  - Counter increments each cycle.
  - Period P is selected from `speed_m` when the counter is 0.
  - When counter = P-1, go to CALC.
- **CALC:** sample `move_d`.
  - Not one-hot, or opposite of the applied direction: keep the applied direction; otherwise adopt `move_d`.
  - Compute next head nx/ny.
  - Out of bounds: go to OVER.
  - Otherwise latch eat = (nx==food_x && ny==food_y) and go to SCAN.
- **SCAN:** one segment compared per cycle, index i from 0.
  - Scan limit L: len-2 if eat=0 (the tail vacates), len-1 if eat=1.
  - Hit on segment i (equal to nx/ny): go to OVER.
  - After index L with no hit: go to SHIFT.
- **SHIFT:** body[k] ← body[k-1] for k ≥ 1; body[0] ← (nx, ny).
  - If eat: len ← min(len+1, MAX_LEN) and pulse `food_eaten`; at MAX_LEN the pulse still fires and the tail drops.
  - Go to WAIT.
- **OVER:** `game_over`=1; body frozen; exit only via START.

Reset values of outputs:
- `head_x`=GRID_W/2, `head_y`=GRID_H/2, `snake_len`=3.
- `food_eaten`=0, `step_done`=0, `game_over`=0.
- FSM=IDLE.

## Timing
- **Step period:** P + 1 (CALC) + (L+1) (SCAN) + 1 (SHIFT) cycles. With len=3 and no eat this is P+4.
- **`step_done`:** registered; asserted in the first WAIT cycle after SHIFT, which is counter=0.
- **`food_eaten`:** asserted in that same cycle.
- **Sampling points:** `move_d` is sampled only in CALC; `speed_m` only at counter=0. Changes at other times take effect on the next step.
- **`game_over`:** rises in the cycle after the collision-detecting CALC or SCAN cycle.
- **Reads:** `rd_x`/`rd_y`/`head_*` are combinational from the body registers; no read latency.

## Configuration
- **`SNAKE_WRAP_EN` defined:** walls wrap instead of colliding.
  - x=GRID_W-1 + RIGHT → 0; x=0 + LEFT → GRID_W-1; y likewise.
  - Only self-collision ends the game.
- **`SNAKE_WRAP_EN` undefined:** leaving the grid raises `game_over`.

## Structure
- **`snake_pkg`:**
  - game-state and direction one-hot localparams;
  - coordinate widths (X_W=6, Y_W=5);
  - packed point struct {x, y};
  - `opposite()` direction function.
- **Sub-module `snake_step_timer`:** period-select counter with pause, clear and wrap-pulse outputs; it is instantiated once.

## Test plan
Bench overrides: GRID_W=8, GRID_H=8, MAX_LEN=4, STEP_SLOW=8, STEP_FAST=4.
- **Reset:** `rst_n`=0 → head (4,4), `snake_len`=3, `game_over`=0, `step_done`=0, `food_eaten`=0.
- **Stepping:** PLAY, RIGHT, `speed_m`=1, food (0,0) → `step_done` every 12 cycles, head x 5, 6, 7. With `speed_m`=0 the period is 8 cycles.
- **Food:** food (5,4), PLAY RIGHT → first step gives len=4 with `food_eaten` pulsing with `step_done`. Food then at (6,4) → len stays 4, `food_eaten` pulses again.
- **Wall:** head (7,4) moving RIGHT → `game_over`=1 one cycle after CALC, body unchanged; with `SNAKE_WRAP_EN`, head becomes (0,4) instead.
- **Self-collision and reversal:**
  - len=4 snake, direction sequence DOWN, LEFT, UP → the UP step hits segment 3 and sets `game_over`.
  - LEFT requested while moving RIGHT → ignored; head x increments.
- **Mid-operation START:** START asserted during SCAN → IDLE next cycle, body reinitialised to (4,4),(3,4),(2,4), `game_over`=0. END asserted during WAIT → counter holds until PLAY returns.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and encodings for the snake step engine: one-hot game states and
// directions, coordinate widths, the body point struct and the FSM state enum.
package snake_pkg;

    localparam logic [3:0] ST_START = 4'b0001;
    localparam logic [3:0] ST_SPEED = 4'b0010;
    localparam logic [3:0] ST_PLAY  = 4'b0100;
    localparam logic [3:0] ST_END   = 4'b1000;

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b1000;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } point_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CALC,
        S_SCAN,
        S_SHIFT,
        S_OVER
    } step_state_e;

    function automatic logic [3:0] opposite(input logic [3:0] dir);
        case (dir)
            DIR_RIGHT: opposite = DIR_LEFT;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_DOWN:  opposite = DIR_UP;
            DIR_UP:    opposite = DIR_DOWN;
            default:   opposite = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/snake_step_engine_if.sv
// Control/status bundle between the key controller + renderer side (master)
// and the snake step engine (slave).
interface snake_step_engine_if #(
    parameter int MAX_LEN = 16
);
    import snake_pkg::*;

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [3:0]     state_m;
    logic [3:0]     move_d;
    logic           speed_m;
    logic [X_W-1:0] food_x;
    logic [Y_W-1:0] food_y;
    logic [IW-1:0]  rd_idx;
    logic [X_W-1:0] rd_x;
    logic [Y_W-1:0] rd_y;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic [LW-1:0]  snake_len;
    logic           food_eaten;
    logic           step_done;
    logic           game_over;

    modport master (
        output state_m, move_d, speed_m, food_x, food_y, rd_idx,
        input  rd_x, rd_y, head_x, head_y, snake_len, food_eaten, step_done, game_over
    );

    modport slave (
        input  state_m, move_d, speed_m, food_x, food_y, rd_idx,
        output rd_x, rd_y, head_x, head_y, snake_len, food_eaten, step_done, game_over
    );

endinterface

// File: rtl/snake_step_timer.sv
// Step-period counter: latches the period from speed_m at count 0, counts while
// running and not paused, and pulses wrap on the last cycle of the period.
module snake_step_timer #(
    parameter int STEP_SLOW = 25_000_000,
    parameter int STEP_FAST = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic pause,
    input  logic clear,
    input  logic speed_m,
    output logic wrap
);
    localparam int PMAX = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
    localparam int CW   = (PMAX > 2) ? $clog2(PMAX) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] lim_q, lim_d;
    logic [CW-1:0] lim_sel, lim_cur;
    logic          active;

    always_comb begin
        active  = run && !pause && !clear;
        lim_sel = speed_m ? CW'(STEP_SLOW - 1) : CW'(STEP_FAST - 1);
        // Period is only chosen at count 0; later speed changes wait for the next step.
        lim_cur = (cnt_q == '0) ? lim_sel : lim_q;
        wrap    = active && (cnt_q == lim_cur);
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active) begin
            if (cnt_q == '0) lim_d = lim_sel;
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

endmodule

// File: rtl/snake_step_engine.sv
// Snake body sequencer: waits a step period, computes the next head, serially
// scans the body for collisions, then shifts/grows. SNAKE_WRAP_EN makes walls wrap.
module snake_step_engine
    import snake_pkg::*;
#(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_LEN   = 16,
    parameter int STEP_SLOW = 25_000_000,
    parameter int STEP_FAST = 12_500_000
) (
    input logic               clk,
    input logic               rst_n,
    snake_step_engine_if.slave bus
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [X_W-1:0] X_MAX    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX    = Y_W'(GRID_H - 1);
    localparam logic [Y_W-1:0] Y_MID    = Y_W'(GRID_H / 2);
    localparam logic [LW-1:0]  LEN_INIT = LW'(3);
    localparam logic [LW-1:0]  LEN_MAX  = LW'(MAX_LEN);

    function automatic point_t init_seg(input int k);
        point_t p;
        p = '0;
        if (k < 3) begin
            p.x = X_W'(GRID_W / 2 - k);
            p.y = Y_MID;
        end
        return p;
    endfunction

    step_state_e   state_q, state_d;
    point_t        body_q [MAX_LEN];
    point_t        body_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [3:0]    dir_q, dir_d;
    point_t        next_q, next_d;
    logic          eat_q, eat_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          game_over_q, game_over_d;
    logic          step_done_q, step_done_d;
    logic          food_eaten_q, food_eaten_d;

    logic          paused, start, tmr_wrap;
    logic [3:0]    dir_sel;
    point_t        cur, nxt, rd_pt;
    logic          at_edge, wall_hit, seg_hit, scan_last;
    int            scan_lim;

    assign start  = (bus.state_m == ST_START);
    assign paused = (bus.state_m != ST_PLAY);

    snake_step_timer #(
        .STEP_SLOW(STEP_SLOW),
        .STEP_FAST(STEP_FAST)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state_q == S_WAIT),
        .pause  (paused),
        .clear  (start),
        .speed_m(bus.speed_m),
        .wrap   (tmr_wrap)
    );

    // Direction arbitration and next-head arithmetic.
    always_comb begin
        dir_sel = dir_q;
        if ($onehot(bus.move_d) && (bus.move_d != opposite(dir_q))) dir_sel = bus.move_d;
        cur     = body_q[0];
        nxt     = cur;
        at_edge = 1'b0;
        case (dir_sel)
            DIR_LEFT: begin
                at_edge = (cur.x == '0);
                nxt.x   = at_edge ? X_MAX : cur.x - X_W'(1);
            end
            DIR_DOWN: begin
                at_edge = (cur.y == Y_MAX);
                nxt.y   = at_edge ? '0 : cur.y + Y_W'(1);
            end
            DIR_UP: begin
                at_edge = (cur.y == '0);
                nxt.y   = at_edge ? Y_MAX : cur.y - Y_W'(1);
            end
            default: begin
                at_edge = (cur.x == X_MAX);
                nxt.x   = at_edge ? '0 : cur.x + X_W'(1);
            end
        endcase
`ifdef SNAKE_WRAP_EN
        wall_hit = 1'b0;
`else
        wall_hit = at_edge;
`endif
    end

    // The tail segment is skipped when not eating because it vacates this step.
    always_comb begin
        scan_lim  = eat_q ? int'(len_q) - 1 : int'(len_q) - 2;
        seg_hit   = (body_q[idx_q] == next_q);
        scan_last = (int'(idx_q) >= scan_lim);
    end

    always_comb begin
        state_d      = state_q;
        body_d       = body_q;
        len_d        = len_q;
        dir_d        = dir_q;
        next_d       = next_q;
        eat_d        = eat_q;
        idx_d        = idx_q;
        game_over_d  = game_over_q;
        step_done_d  = 1'b0;
        food_eaten_d = 1'b0;
        if (start) begin
            state_d     = S_IDLE;
            for (int k = 0; k < MAX_LEN; k++) body_d[k] = init_seg(k);
            len_d       = LEN_INIT;
            dir_d       = DIR_RIGHT;
            eat_d       = 1'b0;
            idx_d       = '0;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.state_m == ST_PLAY) state_d = S_WAIT;
                S_WAIT: if (tmr_wrap) state_d = S_CALC;
                S_CALC: if (!paused) begin
                    dir_d = dir_sel;
                    if (wall_hit) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                    end else begin
                        next_d  = nxt;
                        eat_d   = (nxt.x == bus.food_x) && (nxt.y == bus.food_y);
                        idx_d   = '0;
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: if (!paused) begin
                    if (seg_hit) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                    end else if (scan_last) begin
                        state_d = S_SHIFT;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                S_SHIFT: if (!paused) begin
                    for (int k = 1; k < MAX_LEN; k++) body_d[k] = body_q[k-1];
                    body_d[0] = next_q;
                    if (eat_q) begin
                        if (len_q < LEN_MAX) len_d = len_q + LW'(1);
                        food_eaten_d = 1'b1;
                    end
                    step_done_d = 1'b1;
                    state_d     = S_WAIT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            for (int k = 0; k < MAX_LEN; k++) body_q[k] <= init_seg(k);
            len_q        <= LEN_INIT;
            dir_q        <= DIR_RIGHT;
            next_q       <= '0;
            eat_q        <= 1'b0;
            idx_q        <= '0;
            game_over_q  <= 1'b0;
            step_done_q  <= 1'b0;
            food_eaten_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            body_q       <= body_d;
            len_q        <= len_d;
            dir_q        <= dir_d;
            next_q       <= next_d;
            eat_q        <= eat_d;
            idx_q        <= idx_d;
            game_over_q  <= game_over_d;
            step_done_q  <= step_done_d;
            food_eaten_q <= food_eaten_d;
        end
    end

    always_comb begin
        rd_pt = '0;
        if (int'(bus.rd_idx) < int'(len_q)) rd_pt = body_q[bus.rd_idx];
    end

    assign bus.rd_x       = rd_pt.x;
    assign bus.rd_y       = rd_pt.y;
    assign bus.head_x     = body_q[0].x;
    assign bus.head_y     = body_q[0].y;
    assign bus.snake_len  = len_q;
    assign bus.food_eaten = food_eaten_q;
    assign bus.step_done  = step_done_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_snake_step_engine.sv
// Scoreboard bench: stimulus queues expected step/game-over events (head, length,
// food pulse, cycles since previous event); a monitor pops and compares them.
module tb_snake_step_engine;
    import snake_pkg::*;

    localparam int MAX_LEN = 4;
    localparam int IW      = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snake_step_engine_if #(.MAX_LEN(MAX_LEN)) bus ();

    snake_step_engine #(
        .GRID_W(8), .GRID_H(8), .MAX_LEN(MAX_LEN), .STEP_SLOW(8), .STEP_FAST(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit over;
        int x;
        int y;
        int len;
        bit fe;
        int gap;
    } ev_t;

    ev_t  sb_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   ref_cyc = 0;
    logic go_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: an event is a step_done pulse or a rising game_over.
    initial forever begin
        ev_t a;
        ev_t e;
        @(negedge clk);
        if (rst_n && (bus.step_done || (bus.game_over && !go_prev))) begin
            a.over = !bus.step_done;
            a.x    = int'(bus.head_x);
            a.y    = int'(bus.head_y);
            a.len  = int'(bus.snake_len);
            a.fe   = bus.food_eaten;
            a.gap  = cyc - ref_cyc;
            vectors++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event over=%0b head=(%0d,%0d) len=%0d cyc=%0d required=none",
                         a.over, a.x, a.y, a.len, cyc);
            end else begin
                e = sb_q.pop_front();
                if (a.over != e.over || a.x != e.x || a.y != e.y || a.len != e.len ||
                    a.fe != e.fe || a.gap != e.gap) begin
                    errors++;
                    $display("FAIL event actual over=%0b head=(%0d,%0d) len=%0d fe=%0b gap=%0d required over=%0b head=(%0d,%0d) len=%0d fe=%0b gap=%0d",
                             a.over, a.x, a.y, a.len, a.fe, a.gap,
                             e.over, e.x, e.y, e.len, e.fe, e.gap);
                end
            end
            ref_cyc = cyc;
        end
        go_prev = bus.game_over;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input bit over, input int x, input int y, input int len,
                             input bit fe, input int gap);
        ev_t e;
        e = '{over, x, y, len, fe, gap};
        sb_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_seg(input int i, input int x, input int y);
        bus.rd_idx = IW'(i);
        #1;
        chk($sformatf("seg%0d_x", i), int'(bus.rd_x), x);
        chk($sformatf("seg%0d_y", i), int'(bus.rd_y), y);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.state_m = ST_START;
        repeat (2) @(negedge clk);
    endtask

    task automatic play();
        bus.state_m = ST_PLAY;
        ref_cyc     = cyc;
    endtask

    initial begin
        bus.state_m = ST_START;
        bus.move_d  = DIR_RIGHT;
        bus.speed_m = 1'b1;
        bus.food_x  = '0;
        bus.food_y  = '0;
        bus.rd_idx  = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_head_x", int'(bus.head_x), 4);
        chk("rst_head_y", int'(bus.head_y), 4);
        chk("rst_len", int'(bus.snake_len), 3);
        chk("rst_game_over", int'(bus.game_over), 0);
        chk("rst_step_done", int'(bus.step_done), 0);
        chk("rst_food_eaten", int'(bus.food_eaten), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Slow stepping to the right wall
        play();
        expect_ev(0, 5, 4, 3, 0, 13);
        expect_ev(0, 6, 4, 3, 0, 12);
        expect_ev(0, 7, 4, 3, 0, 12);
`ifdef SNAKE_WRAP_EN
        expect_ev(0, 0, 4, 3, 0, 12);
        drain(80);
`else
        expect_ev(1, 7, 4, 3, 0, 9);
        drain(80);
        repeat (4) @(negedge clk);
        chk("wall_game_over_held", int'(bus.game_over), 1);
        chk("wall_len", int'(bus.snake_len), 3);
        chk_seg(0, 7, 4);
        chk_seg(1, 6, 4);
        chk_seg(2, 5, 4);
        chk_seg(3, 0, 0);
`endif

        // Fast stepping, reversal ignored
        do_start();
        chk("start_clears_game_over", int'(bus.game_over), 0);
        bus.speed_m = 1'b0;
        play();
        expect_ev(0, 5, 4, 3, 0, 9);
        expect_ev(0, 6, 4, 3, 0, 8);
        drain(40);
        bus.move_d = DIR_LEFT;
        expect_ev(0, 7, 4, 3, 0, 8);
        drain(20);

        // Food: grow to MAX_LEN, then eat at the cap
        do_start();
        bus.move_d = DIR_RIGHT;
        bus.food_x = 6'd5;
        bus.food_y = 5'd4;
        play();
        expect_ev(0, 5, 4, 4, 1, 10);
        drain(40);
        bus.food_x = 6'd6;
        expect_ev(0, 6, 4, 4, 1, 10);
        drain(40);
        chk_seg(0, 6, 4);
        chk_seg(1, 5, 4);
        chk_seg(2, 4, 4);
        chk_seg(3, 3, 4);

        // Self-collision: DOWN, LEFT, then UP onto the (non-vacating) tail
        bus.food_x = '0;
        bus.food_y = '0;
        bus.move_d = DIR_DOWN;
        expect_ev(0, 6, 5, 4, 0, 9);
        drain(30);
        bus.move_d = DIR_LEFT;
        expect_ev(0, 5, 5, 4, 0, 9);
        drain(30);
        bus.move_d = DIR_UP;
        bus.food_x = 6'd5;
        bus.food_y = 5'd4;
        expect_ev(1, 5, 5, 4, 0, 9);
        drain(30);
        repeat (2) @(negedge clk);
        chk("self_game_over", int'(bus.game_over), 1);
        chk_seg(0, 5, 5);
        chk_seg(1, 6, 5);
        chk_seg(2, 6, 4);
        chk_seg(3, 5, 4);

        // START during SCAN of the second step
        do_start();
        chk("start2_clears_game_over", int'(bus.game_over), 0);
        bus.move_d  = DIR_RIGHT;
        bus.speed_m = 1'b0;
        bus.food_x  = '0;
        bus.food_y  = '0;
        play();
        expect_ev(0, 5, 4, 3, 0, 9);
        repeat (14) @(negedge clk);
        bus.state_m = ST_START;
        @(negedge clk);
        chk("scan_start_head_x", int'(bus.head_x), 4);
        chk("scan_start_head_y", int'(bus.head_y), 4);
        chk("scan_start_len", int'(bus.snake_len), 3);
        chk("scan_start_game_over", int'(bus.game_over), 0);
        chk_seg(1, 3, 4);
        chk_seg(2, 2, 4);
        chk("scan_start_pending", sb_q.size(), 0);
        repeat (3) @(negedge clk);

        // END during WAIT freezes the counter
        bus.speed_m = 1'b0;
        play();
        expect_ev(0, 5, 4, 3, 0, 14);
        repeat (2) @(negedge clk);
        bus.state_m = ST_END;
        repeat (5) @(negedge clk);
        bus.state_m = ST_PLAY;
        drain(40);
        bus.state_m = ST_START;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
